// File: rtl/player1_recorder_pkg.sv
// Shared widths and state encoding for the player 1 recorder and its consumers.
package player1_recorder_pkg;

    localparam int DEF_SEQ_WIDTH = 18;
    localparam int DEF_LEN_WIDTH = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_DONE   = 2'd2
    } p1_state_t;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for an active-low key with a falling-edge press pulse.
module key_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    logic meta;
    logic sync;
    logic sync_d;

    // Flops come out of reset at 1 so a released key never looks like a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta   <= 1'b1;
            sync   <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            meta   <= key_n;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign level = sync;
    assign press = sync_d & ~sync;

endmodule

// File: rtl/player1_recorder.sv
// Records Player 1's key samples (one per tick) and hands the sequence to player2.
module player1_recorder
    import player1_recorder_pkg::*;
#(
    parameter int SEQ_WIDTH = DEF_SEQ_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 enable,
    input  logic                 value_input,
    input  logic                 finish_input,
    input  logic                 consume,
    output logic [SEQ_WIDTH-1:0] player1_value,
    output logic [LEN_WIDTH-1:0] p1_length,
    output logic                 p1_valid,
    output logic                 recording,
    output logic [SEQ_WIDTH-1:0] q
);

    p1_state_t            state;
    p1_state_t            state_next;
    logic [SEQ_WIDTH-1:0] sr;
    logic [SEQ_WIDTH-1:0] sr_next;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] len_next;
    logic [SEQ_WIDTH-1:0] value_reg;
    logic [LEN_WIDTH-1:0] length_reg;
    logic                 sample_take;
    logic                 full_next;
    logic                 value_level;
    logic                 value_press_unused;
    logic                 finish_level_unused;
    logic                 finish_press;

    key_sync_edge u_value_key (
        .clock (clock),
        .reset (reset),
        .key_n (value_input),
        .level (value_level),
        .press (value_press_unused)
    );

    key_sync_edge u_finish_key (
        .clock (clock),
        .reset (reset),
        .key_n (finish_input),
        .level (finish_level_unused),
        .press (finish_press)
    );

    // The tick sample is folded in before the finish decision, so a tick and a
    // finish in the same cycle both count.
    always_comb begin
        sample_take = (state == S_RECORD) && enable && tick &&
                      (len != LEN_WIDTH'(SEQ_WIDTH));
        sr_next     = sr;
        len_next    = len;
        if (sample_take) begin
            sr_next  = {sr[SEQ_WIDTH-2:0], ~value_level};
            len_next = len + LEN_WIDTH'(1);
        end
        full_next = (len_next == LEN_WIDTH'(SEQ_WIDTH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (enable) state_next = S_RECORD;
            end
            S_RECORD: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else if ((finish_press && (len_next != '0)) || full_next) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (consume) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sr         <= '0;
            len        <= '0;
            value_reg  <= '0;
            length_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        sr         <= '0;
                        len        <= '0;
                        value_reg  <= '0;
                        length_reg <= '0;
                    end
                end
                S_RECORD: begin
                    if (!enable) begin
                        sr         <= '0;
                        len        <= '0;
                        value_reg  <= '0;
                        length_reg <= '0;
                    end else begin
                        sr         <= sr_next;
                        len        <= len_next;
                        value_reg  <= sr_next;
                        length_reg <= len_next;
                    end
                end
                S_DONE: begin
                    if (consume) begin
                        sr         <= '0;
                        len        <= '0;
                        value_reg  <= '0;
                        length_reg <= '0;
                    end
                end
                default: begin
                    sr         <= '0;
                    len        <= '0;
                    value_reg  <= '0;
                    length_reg <= '0;
                end
            endcase
        end
    end

    always_comb begin
        p1_valid  = (state == S_DONE);
        recording = (state == S_RECORD);
    end

    assign player1_value = value_reg;
    assign p1_length     = length_reg;
    assign q             = sr;

endmodule
